spi_responder: RTL
==================

# spi_responder

SPI target (slave) endpoint: the far end of the SPI controller link on the SoC peripheral bus. Oversamples the external SCLK/CS_N/MOSI in the system clock domain, shifts received bits into a parallel word and shifts a preloaded parallel word out on MISO. SPI mode 0 (CPOL=0, CPHA=0), MSB first, continuous back-to-back words while CS_N stays low.

## Interface
- DATA_W, 8: word width in bits (≥2).
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from controller, asynchronous to clk.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from controller, asynchronous.
- miso  out  1  serial data to controller.
- miso_oe  out  1  MISO output enable for the pad tri-state (1 = drive).
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; load occurs on tx_valid && tx_ready.
- rx_data  out  DATA_W  last complete received word; held until next word completes.
- rx_valid  out  1  one-clk pulse, rx_data updated this cycle.
- tx_underrun  out  1  one-clk pulse, word started with holding register empty.
- busy  out  1  cs_n (synchronized) low.

## Operation
- Synchronizers: 2-FF on sclk, cs_n, mosi; one further register on sclk_s/cs_n_s for edge detect. All decisions use synchronized values only.
- Supported SCLK: high and low phases each ≥4 clk periods. Faster SCLK is out of spec; behaviour undefined.
- TX holding register (DATA_W bits + full flag): tx_ready = !full. Handshake sets full. Consumed at word start (below), clearing full; a handshake in the same cycle as consumption is accepted and leaves full=1 with the new data.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on cs_n_s falling edge: bit_cnt=0, rx_shift=0, load tx_shift (word start), miso_oe=1.
- Word start: if full, tx_shift <= holding, full <= 0; else tx_shift <= 0, tx_underrun pulses.
- miso = tx_shift[DATA_W-1] while miso_oe=1, else 0.
- ACTIVE, sclk_s rising edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++. When bit_cnt was DATA_W-1: rx_data <= {rx_shift[DATA_W-2:0], mosi_s}, rx_valid pulse, bit_cnt <= 0, set word_done.
- ACTIVE, sclk_s falling edge: if word_done, word start (next word), clear word_done; else tx_shift <= tx_shift << 1.
- ACTIVE -> IDLE on cs_n_s rising edge, any bit_cnt: miso_oe=0, bit_cnt=0, word_done=0, partial rx discarded (no rx_valid), tx_shift contents lost; holding register untouched.
- cs_n_s rising edge in same cycle as final sclk rising edge: rx_valid still pulses for the complete word, then IDLE.
- SCLK edges while IDLE are ignored.

## Timing
- Reset values: miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, busy 0; state IDLE, full 0.
- Synchronizer latency: an input change first sampled at clk edge N is acted on at edge N+3 (registered outputs change at N+3).
- rx_valid: high exactly one cycle, at N+3 for the DATA_W-th SCLK rise sampled at N.
- miso: valid N+3 after cs_n fall / SCLK fall sampled at N; with ≥4-clk phases it is stable before the next SCLK rise.
- busy and miso_oe follow cs_n with the same 3-cycle latency.
- tx_ready deasserts the cycle after a handshake; reasserts the cycle after word start consumes the holding register.

## Test plan
- Reset: hold rst_n=0 with toggling inputs 5 clk -> all outputs at reset values, tx_ready=1.
- Single word: load 0xA5, controller sends 0x3C in mode 0 at clk/8 -> controller reads 0xA5 on MISO, rx_data=0x3C with one rx_valid pulse, tx_underrun never pulses.
- Back-to-back: load 0x11, refill 0x22 after tx_ready rises, CS_N held low for 16 SCLKs sending 0xF0,0x0F -> MISO 0x11 then 0x22, two rx_valid pulses with 0xF0 then 0x0F.
- Underrun: no load, send 0x81 -> MISO reads 0x00, tx_underrun one pulse at CS_N fall, rx_data=0x81.
- Abort: CS_N high after 5 SCLK rises -> no rx_valid, miso_oe=0, rx_data unchanged; next full transfer of 0x5A received correctly from bit 0.
- Reset mid-word: rst_n low after 3 bits for 1 clk -> outputs at reset values, full=0; subsequent transfer after fresh CS_N fall operates normally.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversampled sclk/cs_n/mosi, MSB-first rx/tx words, back-to-back while cs_n low.
// Acts 3 clks after an input change is first sampled; tx_valid/tx_ready loads the holding register, rx has no backpressure.
module spi_responder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_nxt;
  logic              sclk_m, sclk_s, sclk_d;
  logic              cs_m, cs_s, cs_d;
  logic              mosi_m, mosi_s, mosi_d;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [DATA_W-1:0] hold, tx_shift, rx_shift;
  logic              full, word_done, word_start;
  logic [CNT_W-1:0]  bit_cnt;

  // Synchronizers stay out of reset so a reset while cs_n is low cannot fake an edge.
  always_ff @(posedge clk) begin
    sclk_m <= sclk;
    sclk_s <= sclk_m;
    sclk_d <= sclk_s;
    cs_m   <= cs_n;
    cs_s   <= cs_m;
    cs_d   <= cs_s;
    mosi_m <= mosi;
    mosi_s <= mosi_m;
    mosi_d <= mosi_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      cs_fall   <= ~cs_s & cs_d;
      cs_rise   <= cs_s & ~cs_d;
      busy      <= ~cs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_start = 1'b0;
    if (state == IDLE) begin
      if (cs_fall) begin
        state_nxt  = ACTIVE;
        word_start = 1'b1;
      end
    end else begin
      if (cs_rise) state_nxt = IDLE;
      else if (sclk_fall && word_done) word_start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold        <= '0;
      full        <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (word_start) begin
        if (full) begin
          tx_shift <= hold;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
        full <= 1'b0;
      end
      // A same-cycle load wins over consumption and leaves the register full.
      if (tx_valid && tx_ready) begin
        hold <= tx_data;
        full <= 1'b1;
      end
      if (state == IDLE) begin
        if (cs_fall) begin
          bit_cnt   <= '0;
          rx_shift  <= '0;
          word_done <= 1'b0;
          miso_oe   <= 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[DATA_W-2:0], mosi_d};
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            rx_data   <= {rx_shift[DATA_W-2:0], mosi_d};
            rx_valid  <= 1'b1;
            bit_cnt   <= '0;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        if (cs_rise) begin
          miso_oe   <= 1'b0;
          bit_cnt   <= '0;
          word_done <= 1'b0;
        end else if (sclk_fall) begin
          if (word_done) word_done <= 1'b0;
          else           tx_shift  <= tx_shift << 1;
        end
      end
    end
  end

  assign tx_ready = ~full;
  assign miso     = miso_oe & tx_shift[DATA_W-1];

endmodule
